// File: rtl/clock_period_monitor.sv
// clock_period_monitor: measures high/low phase lengths of a divided clock and tracks lock.
//   clk_in      system clock, everything sampled on posedge
//   reset       synchronous, active-high
//   clk_mon     divided clock under test, already in the clk_in domain
//   rise_pulse  one-cycle strobe after a rising edge of clk_mon
//   fall_pulse  one-cycle strobe after a falling edge of clk_mon
//   high_len    last measured high-phase length
//   low_len     last measured low-phase length
//   len_valid   one-cycle strobe when high_len or low_len was updated
//   locked      level, waveform matches CLOCKS_UP/CLOCKS_DOWN
//   error       one-cycle strobe on a mismatched capture
//   stuck       level, run counter saturated with no edge
module clock_period_monitor #(
    parameter int CLOCKS_UP      = 2,
    parameter int CLOCKS_DOWN    = 2,
    parameter int REGISTER_WIDTH = 8,
    parameter int LOCK_COUNT     = 4
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      clk_mon,
    output logic                      rise_pulse,
    output logic                      fall_pulse,
    output logic [REGISTER_WIDTH-1:0] high_len,
    output logic [REGISTER_WIDTH-1:0] low_len,
    output logic                      len_valid,
    output logic                      locked,
    output logic                      error,
    output logic                      stuck
);
    localparam int GW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t                    state, state_n;
    logic                      mon_q;
    logic [REGISTER_WIDTH-1:0] run_cnt;
    logic [GW-1:0]             good_cnt, good_n;
    logic                      edge_seen, sat, capture, match;
    logic                      locked_n, error_n, stuck_n;

    assign edge_seen = clk_mon != mon_q;
    assign sat       = &run_cnt;
    // IDLE skips the capture: the phase before the first edge is partial
    assign capture   = edge_seen && state != IDLE;
    // a rising edge ends a low phase, a falling edge ends a high phase
    assign match     = clk_mon ? run_cnt == REGISTER_WIDTH'(CLOCKS_DOWN)
                               : run_cnt == REGISTER_WIDTH'(CLOCKS_UP);

    always_comb begin
        state_n  = state;
        good_n   = good_cnt;
        locked_n = locked;
        error_n  = 1'b0;
        stuck_n  = stuck;
        if (edge_seen) begin
            stuck_n = 1'b0;
            if (state == IDLE) begin
                state_n = TRACK;
            end else if (!match) begin
                good_n   = '0;
                locked_n = 1'b0;
                error_n  = 1'b1;
                state_n  = TRACK;
            end else if (state == TRACK) begin
                good_n = good_cnt + GW'(1);
                if (good_n == GW'(LOCK_COUNT)) begin
                    locked_n = 1'b1;
                    state_n  = LOCKED;
                end
            end
        end else if (sat) begin
            stuck_n  = 1'b1;
            locked_n = 1'b0;
            good_n   = '0;
            state_n  = IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            mon_q      <= 1'b0;
            run_cnt    <= '0;
            good_cnt   <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            high_len   <= '0;
            low_len    <= '0;
            len_valid  <= 1'b0;
            locked     <= 1'b0;
            error      <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            state      <= state_n;
            mon_q      <= clk_mon;
            run_cnt    <= edge_seen ? REGISTER_WIDTH'(1) : sat ? run_cnt : run_cnt + REGISTER_WIDTH'(1);
            good_cnt   <= good_n;
            rise_pulse <= edge_seen & clk_mon;
            fall_pulse <= edge_seen & ~clk_mon;
            len_valid  <= capture;
            locked     <= locked_n;
            error      <= error_n;
            stuck      <= stuck_n;
            if (capture && !clk_mon) high_len <= run_cnt;
            if (capture && clk_mon) low_len <= run_cnt;
        end
    end
endmodule

// File: doc/clock_period_monitor.md
Name: clock_period_monitor

Overview:
Downstream checker for a divided clock produced by the team's clock divider. It samples the divided clock as a plain data signal in the clk_in domain, emits one-cycle rise and fall strobes, and measures the length of every high and low phase. It compares each length against the expected up/down counts, declares lock after a run of correct phases, and flags errors and a stuck (edgeless) input.

Parameters:
CLOCKS_UP, 2, expected high-phase length in clk_in cycles; legal range 1..2^REGISTER_WIDTH-2
CLOCKS_DOWN, 2, expected low-phase length in clk_in cycles; legal range 1..2^REGISTER_WIDTH-2
REGISTER_WIDTH, 8, width of the run counter and the length outputs
LOCK_COUNT, 4, consecutive matching phase captures needed to assert locked; at least 1

Ports:
clk_in  input  1  system clock; everything is sampled on posedge
reset  input  1  synchronous, active-high
clk_mon  input  1  divided clock under test; already registered in the clk_in domain, no synchronizer
rise_pulse  output  1  one-cycle strobe for a rising edge of clk_mon
fall_pulse  output  1  one-cycle strobe for a falling edge of clk_mon
high_len  output  REGISTER_WIDTH  last measured high-phase length
low_len  output  REGISTER_WIDTH  last measured low-phase length
len_valid  output  1  one-cycle strobe: high_len or low_len was just updated
locked  output  1  level: the input matches the expected waveform
error  output  1  one-cycle strobe: a captured length mismatched
stuck  output  1  level: run counter saturated with no edge

Behaviour:
- Reset values: every output is 0. Internal mon_q=0, run_cnt=0, good_cnt=0, state=IDLE.
- Registers: mon_q <= clk_mon on every cycle. Edge = (clk_mon != mon_q). Rising when clk_mon=1; falling when clk_mon=0.
- Run counter:
  - On an edge, run_cnt <= 1.
  - With no edge, run_cnt <= run_cnt+1, saturating at 2^W-1.
  - run_cnt counts in every state.
  - At a falling edge, run_cnt holds the length of the high phase just ended; at a rising edge, the low phase.
- Strobes: rise_pulse and fall_pulse are registered. They are high for exactly one cycle, the cycle after the edge is sampled.
- States:
  - IDLE: the first level after reset or stuck is partial, so it is not measured. On any edge go to TRACK with no capture and no len_valid. The strobes still fire.
  - TRACK: on a falling edge, high_len <= run_cnt and compare with CLOCKS_UP. On a rising edge, low_len <= run_cnt and compare with CLOCKS_DOWN. len_valid pulses with the capture.
    - Match: good_cnt <= good_cnt+1. When the new value equals LOCK_COUNT, locked <= 1 and go to LOCKED.
    - Mismatch: good_cnt <= 0 and error pulses.
  - LOCKED: same capture and compare.
    - Match: stay.
    - Mismatch: locked <= 0, good_cnt <= 0, error pulses, go to TRACK.
- Stuck condition: run_cnt already at 2^W-1 with no edge in this cycle.
  - stuck <= 1, locked <= 0, good_cnt <= 0, state <= IDLE.
  - stuck holds until the next edge, which clears it in the same update that handles the edge.
  - If saturation and an edge coincide, the edge wins.
- A saturated length captured at an edge is compared normally and is always a mismatch, given the legal parameter range.
- Latency: every registered output reflects the edge one cycle after clk_mon changes.
- Reset asserted mid-operation returns everything to reset values on that edge; partial measurements are discarded.
- good_cnt width is clog2(LOCK_COUNT+1); it never exceeds LOCK_COUNT.

Test Plan:
- Divider at 2/2 drives clk_mon, reset released -> first rise gives rise_pulse with no len_valid. The next four edges give len_valid with high_len=2 / low_len=2. locked rises the cycle after the 4th capture; error stays 0.
- clk_mon driven high 3, low 2 while expecting 2/2 -> at each fall, high_len=3 and an error pulse; good_cnt resets, so locked never asserts; every low_len=2.
- Locked at 2/2, then one high phase of 1 cycle -> high_len=1, error for one cycle, locked drops the same cycle; relock after 4 further good captures.
- clk_mon held 0 after reset with W=8 -> stuck asserts the cycle after the 256th clk_in edge; locked=0. A later rise clears stuck, gives rise_pulse, and does not capture (IDLE).
- Reset asserted mid-high-phase while locked -> next cycle all outputs are 0. Following edges re-acquire from IDLE, with the first phase unmeasured.
- clk_mon=1 on the first post-reset cycle -> treated as a rise: rise_pulse=1, state TRACK, no len_valid.
